dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single data-memory port between the core load/store path and a debug/host access port. Sits between the core's `o_mem_*` outputs and the data RAM (synchronous read, one-cycle latency) and stalls the core whenever the debug port owns the slot. The core normally has priority. A starvation counter guarantees debug service, and a halt mode gives debug exclusive ownership of the RAM.

## Interface
Parameters:
- `DATA_W`, 32: data width.
- `ADDR_W`, 13: RAM address width. Low `ADDR_W` bits of the byte address are passed through.
- `STARVE_LIMIT`, 8: consecutive ungranted debug-request cycles before a forced debug slot. Range 1..(2^`CNT_W`−1).
- `CNT_W`, 4: starvation counter width.

Ports:
- `clk_sys` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `i_core_wen` in 1: core write request.
- `i_core_ren` in 1: core read request.
- `i_core_addr` in 32: core byte address.
- `i_core_wdata` in `DATA_W`: core write data.
- `o_core_rdata` out `DATA_W`: read data to core.
- `o_core_stall` out 1: core access not taken this cycle; core holds its request.
- `i_dbg_req` in 1: debug access request, held until granted.
- `i_dbg_we` in 1: 1 = write, 0 = read.
- `i_dbg_addr` in 32: debug byte address.
- `i_dbg_wdata` in `DATA_W`: debug write data.
- `o_dbg_gnt` out 1: debug access issued this cycle.
- `o_dbg_rvalid` out 1: debug read data valid.
- `o_dbg_rdata` out `DATA_W`: debug read data.
- `i_dbg_halt` in 1: request exclusive debug ownership.
- `o_halted` out 1: arbiter is in HALT.
- `o_mem_wen` out 1: RAM write enable.
- `o_mem_addr` out `ADDR_W`: RAM address.
- `o_mem_wdata` out `DATA_W`: RAM write data.
- `i_mem_rdata` in `DATA_W`: RAM read data, valid the cycle after the address.

## Operation
- FSM states: RUN, FORCE, HALT. Reset state is RUN.
- RUN:
  - Core access (`i_core_wen|i_core_ren`) is granted and debug waits.
  - If the core is idle and `i_dbg_req`=1, debug is granted in the same cycle (`o_dbg_gnt`=1).
- Starvation counter `scnt`:
  - In RUN, increments each cycle `i_dbg_req`=1 and `o_dbg_gnt`=0. Saturates at `STARVE_LIMIT`.
  - Clears on `o_dbg_gnt`=1 or `i_dbg_req`=0.
  - When `scnt` reaches `STARVE_LIMIT`, next state is FORCE.
- FORCE (exactly one cycle):
  - `o_dbg_gnt`=1 if `i_dbg_req`.
  - `o_core_stall`=1 if a core access is pending.
  - `scnt` clears and the FSM returns to RUN.
  - If `i_dbg_req` dropped in the meantime, the slot goes unused and the core is not stalled.
- HALT:
  - Entered from RUN or FORCE when `i_dbg_halt`=1. Entry is evaluated after the FORCE slot, so FORCE completes first.
  - `o_halted`=1.
  - `o_core_stall`=1 whenever the core requests.
  - Every `i_dbg_req` cycle is granted.
  - Returns to RUN on `i_dbg_halt`=0, with `scnt`=0.
- Mux:
  - `o_mem_*` comes from the granted requester.
  - With no grant: `o_mem_wen`=0 and address/wdata are 0.
  - `o_mem_wen` = `i_core_wen` or `i_dbg_we` of the winner. A read drives the address only.
- Read return:
  - Register `rd_owner` (none/core/dbg) records who issued a read.
  - `o_core_rdata` and `o_dbg_rdata` both equal `i_mem_rdata`.
  - `o_dbg_rvalid`=1 the cycle after a debug read grant.
  - The core samples `o_core_rdata` the cycle after an unstalled read.
- Core `i_core_wen` and `i_core_ren` both high: treated as a write.
- Reset mid-operation: FSM→RUN, `scnt`=0, `rd_owner`=none. A pending `o_dbg_rvalid` is dropped, and the debug master reissues the request.

## Timing
- Reset values (during `rst` and the first cycle after):
  - `o_dbg_gnt`=0, `o_dbg_rvalid`=0, `o_halted`=0, `o_mem_wen`=0, `o_mem_addr`=0.
  - `o_core_stall`=0.
  - `o_core_rdata`/`o_dbg_rdata` follow `i_mem_rdata`.
- `o_dbg_gnt`, `o_core_stall` and `o_mem_*` are combinational from state and inputs, with no added latency.
- `o_dbg_rvalid` and `o_halted` are registered.
- Write latency: RAM written at the `clk_sys` edge ending the grant cycle.
- Read latency: data valid 1 cycle after the grant.
- Worst-case debug wait in RUN with a continuously busy core: `STARVE_LIMIT`+1 cycles from `i_dbg_req` rise to `o_dbg_gnt`.
- `i_dbg_halt` rising: `o_halted`=1 one cycle later. Stall gating applies from the first HALT cycle.

## Test plan
- Core only: core write 0xDEADBEEF @0x0010, then read @0x0010 → `o_mem_wen` pulse, `o_core_stall` never 1, `o_core_rdata`=0xDEADBEEF the cycle after the read.
- Idle core: debug read @0x0020 → `o_dbg_gnt` in the request cycle, `o_dbg_rvalid`=1 next cycle with the RAM data, `o_core_stall`=0.
- Starvation: core accesses every cycle plus debug write; `STARVE_LIMIT`=8 → `o_dbg_gnt` exactly at cycle 9, `o_core_stall`=1 for that single cycle only, core write lands one cycle late.
- Halt: `i_dbg_halt`=1, core requesting continuously, 4 debug reads back-to-back → `o_halted`=1, `o_core_stall`=1 throughout, 4 grants and 4 rvalids; release → core resumes within 1 cycle.
- Collision: debug read granted in FORCE while core stalled → `o_dbg_rvalid` next cycle; `o_core_rdata` not consumed until the core's own read.
- Reset mid-read: `rst` asserted in the cycle after a debug read grant → `o_dbg_rvalid`=0, state RUN, `scnt`=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single data-RAM port between the core load/store path and a
// debug/host port. The core normally wins. A starvation counter forces a
// debug slot after STARVE_LIMIT denied cycles. A halt mode gives debug
// exclusive use of the RAM while the core is held stalled.
//
// Ports
//   clk_sys, rst         : clock, synchronous active-high reset
//   i_core_*             : core request (wen/ren/addr/wdata)
//   o_core_rdata/stall   : read data to core, core-not-taken indication
//   i_dbg_req/we/addr/wdata : debug request, held until o_dbg_gnt
//   o_dbg_gnt            : debug access issued this cycle
//   o_dbg_rvalid/rdata   : debug read return, one cycle after a read grant
//   i_dbg_halt, o_halted : exclusive debug ownership request / status
//   o_mem_*, i_mem_rdata : RAM port (synchronous read, one-cycle latency)
module dmem_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 13,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              i_core_wen,
  input  logic              i_core_ren,
  input  logic [31:0]       i_core_addr,
  input  logic [DATA_W-1:0] i_core_wdata,
  output logic [DATA_W-1:0] o_core_rdata,
  output logic              o_core_stall,
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic [31:0]       i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic              o_dbg_gnt,
  output logic              o_dbg_rvalid,
  output logic [DATA_W-1:0] o_dbg_rdata,
  input  logic              i_dbg_halt,
  output logic              o_halted,
  output logic              o_mem_wen,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {RUN, FORCE, HALT} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_DBG} owner_e;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_e           state_q, state_d;
  owner_e           rdOwner_q, rdOwner_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic             halted_q;

  logic coreReq;
  logic coreGnt;
  logic dbgGnt;
  logic coreStall;
  logic unusedAddrBits;

  assign coreReq = i_core_wen | i_core_ren;

  // Only the low ADDR_W address bits reach the RAM.
  assign unusedAddrBits = ^{i_core_addr[31:ADDR_W], i_dbg_addr[31:ADDR_W]};

  // Grant decision. Nothing is granted while reset is held so the RAM
  // cannot be written and outputs sit at their idle values. In FORCE a
  // dropped debug request leaves the slot to the core.
  always_comb begin
    coreGnt   = 1'b0;
    dbgGnt    = 1'b0;
    coreStall = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          coreGnt = coreReq;
          dbgGnt  = !coreReq && i_dbg_req;
        end
        FORCE: begin
          dbgGnt    = i_dbg_req;
          coreStall = coreReq && i_dbg_req;
          coreGnt   = coreReq && !i_dbg_req;
        end
        HALT: begin
          dbgGnt    = i_dbg_req;
          coreStall = coreReq;
        end
        default: begin
          coreGnt = 1'b0;
        end
      endcase
    end
  end

  // Next state and starvation count. The counter only runs in RUN; a
  // pending forced slot takes priority over halt entry so FORCE always
  // completes before HALT.
  always_comb begin
    state_d = state_q;
    scnt_d  = '0;
    case (state_q)
      RUN: begin
        if (i_dbg_req && !dbgGnt) begin
          scnt_d = (scnt_q == LIMIT) ? LIMIT : scnt_q + 1'b1;
        end
        if (scnt_d == LIMIT) begin
          state_d = FORCE;
        end else if (i_dbg_halt) begin
          state_d = HALT;
        end
      end
      FORCE:   state_d = i_dbg_halt ? HALT : RUN;
      HALT:    state_d = i_dbg_halt ? HALT : RUN;
      default: state_d = RUN;
    endcase
  end

  // Remember who issued a read so the return can be flagged next cycle.
  // A core access with both enables set is a write and returns nothing.
  always_comb begin
    rdOwner_d = OWN_NONE;
    if (dbgGnt && !i_dbg_we) begin
      rdOwner_d = OWN_DBG;
    end else if (coreGnt && !i_core_wen) begin
      rdOwner_d = OWN_CORE;
    end
  end

  // RAM port mux. Write data is only driven for writes; an idle port
  // presents all zeros.
  always_comb begin
    o_mem_wen   = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (dbgGnt) begin
      o_mem_wen  = i_dbg_we;
      o_mem_addr = i_dbg_addr[ADDR_W-1:0];
      if (i_dbg_we) begin
        o_mem_wdata = i_dbg_wdata;
      end
    end else if (coreGnt) begin
      o_mem_wen  = i_core_wen;
      o_mem_addr = i_core_addr[ADDR_W-1:0];
      if (i_core_wen) begin
        o_mem_wdata = i_core_wdata;
      end
    end
  end

  // State registers; o_halted is registered from the next state so it
  // rises one cycle after i_dbg_halt.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q   <= RUN;
      scnt_q    <= '0;
      rdOwner_q <= OWN_NONE;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      rdOwner_q <= rdOwner_d;
      halted_q  <= (state_d == HALT);
    end
  end

  // Registered status is masked during reset so a read return in flight
  // when reset arrives is dropped immediately.
  assign o_dbg_rvalid = (rdOwner_q == OWN_DBG) && !rst;
  assign o_halted     = halted_q && !rst;
  assign o_dbg_gnt    = dbgGnt;
  assign o_core_stall = coreStall;
  assign o_core_rdata = i_mem_rdata;
  assign o_dbg_rdata  = i_mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter: a synchronous RAM model on the
// memory port, a behavioural reference model of the arbitration rules,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_arbiter;

  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 13;
  localparam int STARVE_LIMIT = 8;
  localparam int CNT_W        = 4;
  localparam int DEPTH        = 1 << ADDR_W;

  logic              clk_sys = 1'b0;
  logic              rst = 1'b1;
  logic              coreWen = 1'b0;
  logic              coreRen = 1'b0;
  logic [31:0]       coreAddr = '0;
  logic [DATA_W-1:0] coreWdata = '0;
  logic [DATA_W-1:0] coreRdata;
  logic              coreStall;
  logic              dbgReq = 1'b0;
  logic              dbgWe = 1'b0;
  logic [31:0]       dbgAddr = '0;
  logic [DATA_W-1:0] dbgWdata = '0;
  logic              dbgGnt;
  logic              dbgRvalid;
  logic [DATA_W-1:0] dbgRdata;
  logic              dbgHalt = 1'b0;
  logic              halted;
  logic              memWen;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] memRdata = '0;
  logic              clearRam = 1'b1;

  int assertCount = 0;
  int failCount   = 0;

  // Model expectations for this cycle, used by the stimulus to honour the
  // hold-until-served protocol of both requesters.
  logic modelGnt   = 1'b0;
  logic modelStall = 1'b0;

  logic [DATA_W-1:0] ram [0:DEPTH-1];

  // 10 ns clock
  always #5 clk_sys = ~clk_sys;

  dmem_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)
  ) dut (
    .clk_sys(clk_sys), .rst(rst),
    .i_core_wen(coreWen), .i_core_ren(coreRen), .i_core_addr(coreAddr),
    .i_core_wdata(coreWdata), .o_core_rdata(coreRdata), .o_core_stall(coreStall),
    .i_dbg_req(dbgReq), .i_dbg_we(dbgWe), .i_dbg_addr(dbgAddr), .i_dbg_wdata(dbgWdata),
    .o_dbg_gnt(dbgGnt), .o_dbg_rvalid(dbgRvalid), .o_dbg_rdata(dbgRdata),
    .i_dbg_halt(dbgHalt), .o_halted(halted),
    .o_mem_wen(memWen), .o_mem_addr(memAddr), .o_mem_wdata(memWdata),
    .i_mem_rdata(memRdata)
  );

  // Synchronous RAM with one-cycle read latency, cleared while the bench
  // holds clearRam during the initial reset.
  always @(posedge clk_sys) begin
    if (clearRam) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else if (memWen) begin
      ram[memAddr] <= memWdata;
    end
    memRdata <= ram[memAddr];
  end

  // One comparison: counts it, reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input logic r, input logic cw, input logic cr,
                               input logic [31:0] ca, input logic [31:0] cd,
                               input logic dr, input logic dw,
                               input logic [31:0] da, input logic [31:0] dd,
                               input logic h);
    @(posedge clk_sys);
    #1;
    rst = r; coreWen = cw; coreRen = cr; coreAddr = ca; coreWdata = cd;
    dbgReq = dr; dbgWe = dw; dbgAddr = da; dbgWdata = dd; dbgHalt = h;
  endtask

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    a = $urandom();
    return (a & 32'hFFFF_E000) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  // Reference model, evaluated mid-cycle. Tracks how long debug has been
  // refused, whether this cycle is the forced debug slot, whether debug
  // owns the RAM exclusively, plus a word-array image of the RAM to
  // predict read data.
  initial begin : model
    logic [DATA_W-1:0] refMem [0:DEPTH-1];
    int                streak;
    bit                forceNow, inHalt, lastDbgRd, lastCoreRd;
    logic [DATA_W-1:0] expDbgData, expCoreData, eWdata;
    logic              cReq, cg, dg, st, eWen;
    logic [ADDR_W-1:0] eAddr;
    for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
    streak = 0; forceNow = 0; inHalt = 0; lastDbgRd = 0; lastCoreRd = 0;
    expDbgData = '0; expCoreData = '0;
    forever begin
      @(negedge clk_sys);
      cReq = coreWen | coreRen;
      if (rst) begin
        checkOutput("rst_gnt", 32'(dbgGnt), 32'd0);
        checkOutput("rst_stall", 32'(coreStall), 32'd0);
        checkOutput("rst_wen", 32'(memWen), 32'd0);
        checkOutput("rst_addr", 32'(memAddr), 32'd0);
        checkOutput("rst_rvalid", 32'(dbgRvalid), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        streak = 0; forceNow = 0; inHalt = 0; lastDbgRd = 0; lastCoreRd = 0;
        modelGnt = 1'b0; modelStall = 1'b0;
      end else begin
        checkOutput("halted", 32'(halted), 32'(inHalt));
        checkOutput("rvalid", 32'(dbgRvalid), 32'(lastDbgRd));
        if (lastDbgRd) checkOutput("dbg_rdata", dbgRdata, expDbgData);
        if (lastCoreRd) checkOutput("core_rdata", coreRdata, expCoreData);
        if (inHalt) begin
          dg = dbgReq; st = cReq; cg = 1'b0;
        end else if (forceNow) begin
          dg = dbgReq; st = cReq & dbgReq; cg = cReq & !dbgReq;
        end else begin
          cg = cReq; dg = !cReq & dbgReq; st = 1'b0;
        end
        eWen = 1'b0; eAddr = '0; eWdata = '0;
        if (dg) begin
          eWen = dbgWe; eAddr = dbgAddr[ADDR_W-1:0];
          if (dbgWe) eWdata = dbgWdata;
        end else if (cg) begin
          eWen = coreWen; eAddr = coreAddr[ADDR_W-1:0];
          if (coreWen) eWdata = coreWdata;
        end
        checkOutput("dbg_gnt", 32'(dbgGnt), 32'(dg));
        checkOutput("core_stall", 32'(coreStall), 32'(st));
        checkOutput("mem_wen", 32'(memWen), 32'(eWen));
        checkOutput("mem_addr", 32'(memAddr), 32'(eAddr));
        checkOutput("mem_wdata", memWdata, eWdata);
        lastDbgRd  = dg && !dbgWe;
        lastCoreRd = cg && !coreWen;
        if (lastDbgRd) expDbgData = refMem[eAddr];
        if (lastCoreRd) expCoreData = refMem[eAddr];
        if (eWen) refMem[eAddr] = eWdata;
        modelGnt = dg; modelStall = st;
        if (inHalt) begin
          inHalt = dbgHalt; streak = 0;
        end else if (forceNow) begin
          forceNow = 0; streak = 0; inHalt = dbgHalt;
        end else begin
          streak = (dbgReq && !dg) ? streak + 1 : 0;
          if (streak >= STARVE_LIMIT) begin
            forceNow = 1; streak = 0;
          end else if (dbgHalt) begin
            inHalt = 1;
          end
        end
      end
    end
  end

  // Directed scenarios with literal expectations, then random traffic.
  initial begin : stimulus
    int gntCycle, stallCycles, gntCount, rvCount, haltCount, n;
    logic [31:0] lateAddr;
    logic r, cw, cr, dr, dw, h;
    logic [31:0] ca, cd, da, dd;
    int kind;

    // Reset, then the first cycle after reset.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    clearRam = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_sys);
    checkOutput("post_rst_halted", 32'(halted), 32'd0);
    checkOutput("post_rst_rvalid", 32'(dbgRvalid), 32'd0);

    // Core-only write then read back.
    applyStimulus(0, 1, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    @(negedge clk_sys);
    checkOutput("core_wr_wen", 32'(memWen), 32'd1);
    checkOutput("core_wr_addr", 32'(memAddr), 32'h10);
    applyStimulus(0, 0, 1, 32'h10, 0, 0, 0, 0, 0, 0);
    @(negedge clk_sys);
    checkOutput("core_rd_stall", 32'(coreStall), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_sys);
    checkOutput("core_rd_data", coreRdata, 32'hDEADBEEF);

    // Idle core: debug write then debug read of the same word.
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h20, 32'hCAFEF00D, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h20, 0, 0);
    @(negedge clk_sys);
    checkOutput("idle_dbg_gnt", 32'(dbgGnt), 32'd1);
    checkOutput("idle_dbg_stall", 32'(coreStall), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_sys);
    checkOutput("idle_dbg_rvalid", 32'(dbgRvalid), 32'd1);
    checkOutput("idle_dbg_rdata", dbgRdata, 32'hCAFEF00D);

    // Starvation: core writes every cycle, debug write waits for the
    // forced slot; the stalled core write must appear the cycle after.
    gntCycle = 0; stallCycles = 0; n = 1; lateAddr = '0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      applyStimulus(0, 1, 0, 32'h100 + 32'(4 * n), 32'(n), gntCycle == 0, 1,
                    32'h80, 32'h55AA55AA, 0);
      @(negedge clk_sys);
      if (dbgGnt && gntCycle == 0) gntCycle = cyc;
      if (cyc == 10) lateAddr = 32'(memAddr);
      if (coreStall) stallCycles++;
      else n++;
    end
    checkOutput("starve_gnt_cycle", 32'(gntCycle), 32'd9);
    checkOutput("starve_stall_cycles", 32'(stallCycles), 32'd1);
    checkOutput("starve_late_core_wr", lateAddr, 32'h124);

    // Collision: forced debug read while the core keeps reading.
    gntCycle = 0;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      applyStimulus(0, 0, 1, 32'h10, 0, gntCycle == 0, 0, 32'h20, 0, 0);
      @(negedge clk_sys);
      if (dbgGnt && gntCycle == 0) gntCycle = cyc;
      if (cyc == 10) begin
        checkOutput("collide_rvalid", 32'(dbgRvalid), 32'd1);
        checkOutput("collide_rdata", dbgRdata, 32'hCAFEF00D);
      end
    end
    checkOutput("collide_gnt_cycle", 32'(gntCycle), 32'd9);

    // Halt with the core reading continuously and four debug reads.
    applyStimulus(0, 0, 1, 32'h10, 0, 0, 0, 0, 0, 1);
    @(negedge clk_sys);
    checkOutput("halt_not_yet", 32'(halted), 32'd0);
    gntCount = 0; rvCount = 0; stallCycles = 0; haltCount = 0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      applyStimulus(0, 0, 1, 32'h10, 0, cyc <= 4, 0, 32'h20 + 32'(4 * (cyc % 2)), 0, 1);
      @(negedge clk_sys);
      if (dbgGnt) gntCount++;
      if (dbgRvalid) rvCount++;
      if (coreStall) stallCycles++;
      if (halted) haltCount++;
    end
    checkOutput("halt_gnts", 32'(gntCount), 32'd4);
    checkOutput("halt_rvalids", 32'(rvCount), 32'd4);
    checkOutput("halt_stalls", 32'(stallCycles), 32'd6);
    checkOutput("halt_cycles", 32'(haltCount), 32'd6);
    applyStimulus(0, 0, 1, 32'h10, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h10, 0, 0, 0, 0, 0, 0);
    @(negedge clk_sys);
    checkOutput("release_stall", 32'(coreStall), 32'd0);
    checkOutput("release_halted", 32'(halted), 32'd0);

    // Reset arriving the cycle after a debug read grant.
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h20, 0, 0);
    @(negedge clk_sys);
    checkOutput("rstrd_gnt", 32'(dbgGnt), 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_sys);
    checkOutput("rstrd_rvalid", 32'(dbgRvalid), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_sys);
    checkOutput("rstrd_after_rvalid", 32'(dbgRvalid), 32'd0);

    // Random traffic; both requesters hold a request the model says was
    // not served, with an occasional debug drop.
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 399) == 0);
      if (modelStall) begin
        cw = coreWen; cr = coreRen; ca = coreAddr; cd = coreWdata;
      end else begin
        kind = $urandom_range(0, 7);
        cw = (kind >= 5);
        cr = (kind >= 2 && kind <= 4) || kind == 7;
        ca = randAddr(); cd = $urandom();
      end
      if (dbgReq && !modelGnt && $urandom_range(0, 15) != 0) begin
        dr = dbgReq; dw = dbgWe; da = dbgAddr; dd = dbgWdata;
      end else begin
        dr = ($urandom_range(0, 2) == 0);
        dw = 1'($urandom_range(0, 1));
        da = randAddr(); dd = $urandom();
      end
      h = dbgHalt;
      if ($urandom_range(0, 59) == 0) h = !h;
      applyStimulus(r, cw, cr, ca, cd, dr, dw, da, dd, h);
    end

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_sys);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
